// File: rtl/booth_multiplier_param_if.sv
// Control and data bundle shared by the radix-4 Booth multiplier and its requester.
// The master drives the start/clear strobes and the operands. The slave returns the product and status.
interface booth_multiplier_param_if #(
  parameter int WIDTH = 64
);
  logic                 op_start;
  logic                 op_clear;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplicand;
  logic [2*WIDTH-1:0]   result;
  logic                 busy;
  logic                 op_done;

  modport master (
    output op_start, op_clear, signed_mode, multiplier, multiplicand,
    input  result, busy, op_done
  );

  modport slave (
    input  op_start, op_clear, signed_mode, multiplier, multiplicand,
    output result, busy, op_done
  );
endinterface

// File: rtl/booth_multiplier_param.sv
// Sequential radix-4 Booth multiplier that retires one Booth digit per clock.
// Both operands are widened by two bits so that one datapath handles signed and unsigned operation.
module booth_multiplier_param #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH/2+2)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  booth_multiplier_param_if.slave bus
);
  localparam int XW = WIDTH + 2;
  localparam int AW = 2*WIDTH + 4;
  localparam int N  = WIDTH/2 + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N-1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("booth_multiplier_param: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [XW:0]          mplr_reg, mplr_next;
  logic [AW-1:0]        mcand_reg, mcand_next;
  logic [AW-1:0]        acc_reg, acc_next;
  logic [2*WIDTH-1:0]   result_reg, result_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;

  logic [XW-1:0]        ext_mplr;
  logic [XW-1:0]        ext_mcand;
  logic [AW-1:0]        multiple;
  logic [AW-1:0]        acc_sum;

  assign ext_mplr[WIDTH-1:0]  = bus.multiplier;
  assign ext_mcand[WIDTH-1:0] = bus.multiplicand;
  for (genvar gi = WIDTH; gi < XW; gi++) begin : g_ext
    assign ext_mplr[gi]  = bus.signed_mode & bus.multiplier[WIDTH-1];
    assign ext_mcand[gi] = bus.signed_mode & bus.multiplicand[WIDTH-1];
  end

  // mcand_reg is shifted left by two every step, so it already carries the 4^counter weight.
  always_comb begin
    multiple = '0;
    case (mplr_reg[2:0])
      3'b001, 3'b010: multiple = mcand_reg;
      3'b011:         multiple = mcand_reg << 1;
      3'b100:         multiple = -(mcand_reg << 1);
      3'b101, 3'b110: multiple = -mcand_reg;
      default:        multiple = '0;
    endcase
  end

  assign acc_sum = acc_reg + multiple;

  always_comb begin
    state_next  = state_reg;
    mplr_next   = mplr_reg;
    mcand_next  = mcand_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    cnt_next    = cnt_reg;

    if (bus.op_clear) begin
      state_next  = S_IDLE;
      mplr_next   = '0;
      mcand_next  = '0;
      acc_next    = '0;
      result_next = '0;
      cnt_next    = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.op_start) begin
            mplr_next  = {ext_mplr, 1'b0};
            mcand_next = {{(AW-XW){ext_mcand[XW-1]}}, ext_mcand};
            acc_next   = '0;
            cnt_next   = '0;
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          acc_next   = acc_sum;
          mplr_next  = {mplr_reg[XW], mplr_reg[XW], mplr_reg[XW:2]};
          mcand_next = mcand_reg << 2;
          cnt_next   = cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            result_next = acc_sum[2*WIDTH-1:0];
            state_next  = S_DONE;
          end
        end
        S_DONE: begin
          state_next = S_DONE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      mplr_reg   <= '0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      mplr_reg   <= mplr_next;
      mcand_reg  <= mcand_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign bus.result  = result_reg;
  assign bus.busy    = (state_reg == S_EXEC);
  assign bus.op_done = (state_reg == S_DONE);
endmodule

// File: doc/booth_multiplier_param.md
Name: booth_multiplier_param

Overview:
Parametrised radix-4 Booth multiplier, the next generation of the fixed 64-bit sequential multiplier. Operand width is a parameter. Signed or unsigned operation is selected per operation. Exposes an explicit busy flag. Sits on the same op_start/op_clear/op_done control interface as the existing multiplier, so the datapath top level can swap it in directly.

Parameters:
WIDTH, 64, operand width in bits; must be even and >= 4 (elaboration error otherwise)
CNT_W, $clog2(WIDTH/2+2), iteration counter width; derived, not to be overridden

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
op_start  input  1  start request; sampled only in IDLE
op_clear  input  1  synchronous clear to IDLE; highest priority after reset_n
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with op_start
multiplier  input  WIDTH  multiplier operand; sampled with op_start
multiplicand  input  WIDTH  multiplicand operand; sampled with op_start
result  output  2*WIDTH  product; valid while op_done=1
busy  output  1  high in EXEC
op_done  output  1  high in DONE

Behaviour:
- Reset (reset_n=0, async): state=IDLE, result=0, busy=0, op_done=0, counter=0, internal operand registers=0.
- op_clear=1 at a clock edge: same values as reset, in any state (including mid-EXEC). op_start is ignored on that edge.
- FSM states:
  - IDLE -> EXEC on op_start=1.
  - EXEC -> DONE when counter reaches N-1.
  - DONE -> IDLE only via op_clear.
- op_start is ignored in EXEC and DONE. No restart without op_clear.
- Start edge (E0) actions:
  - Extend both operands to WIDTH+2 bits: sign-extend if signed_mode=1, else zero-extend.
  - Load the multiplier register as {ext_multiplier, 1'b0} (Booth guard bit).
  - Load the multiplicand register.
  - Clear the accumulator and counter=0. Enter EXEC.
- Iteration count: N = WIDTH/2 + 1. The extra step covers the zero-extended unsigned MSB pair.
- Each EXEC edge:
  - Examine the low 3 bits of the multiplier register: 000/111 -> +0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Add the multiple to the accumulator, with M weighted by 4^counter.
  - Shift the multiplier register right by 2 (arithmetic).
  - counter += 1.
- Arithmetic: the accumulator is 2*WIDTH+4 bits wide and wraps modulo its width. result = low 2*WIDTH bits of the accumulator, registered on the final EXEC edge (EN).
- Latency: op_done and result become valid N cycles after the start edge (WIDTH=64: 33; WIDTH=8: 5).
  - busy=1 from after E0 through EN.
  - op_done=1 from after EN until op_clear or reset.
- Result holds stable in DONE. Operand input changes after E0 have no effect.
- Simultaneous events:
  - op_start with op_clear: clear wins.
  - op_start with reset_n low: reset wins.
- Exact for all operand pairs in both modes. Boundary cases: signed -2^(W-1) x -2^(W-1), unsigned all-ones x all-ones.

Test Plan:
- WIDTH=8, signed, multiplier=8'hFD (-3), multiplicand=8'h05 -> result=16'hFFF1, op_done rises exactly 5 cycles after start, busy high for those 5 cycles.
- WIDTH=8, unsigned, 8'hFF x 8'hFF -> result=16'hFE01. Same operands signed -> 16'h0001.
- WIDTH=8, signed, 8'h80 x 8'h80 -> 16'h4000. Signed 8'h80 x 8'h7F -> 16'hC080.
- WIDTH=64, unsigned, 64'hFFFF_FFFF_FFFF_FFFF squared -> 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, op_done after 33 cycles. Random signed/unsigned pairs (>=1000) must match a reference model.
- Assert op_clear at cycle 2 of EXEC -> busy=0, op_done=0, result=0 next edge. A new op_start then completes correctly. A second op_start pulsed during EXEC is ignored (latency and result unchanged).
- Assert reset_n low asynchronously mid-EXEC and in DONE -> all outputs 0 immediately without a clock edge. op_start together with op_clear in IDLE -> stays IDLE.
